// File: rtl/led_driver_pwm.sv
// rtl/led_driver_pwm.sv - serial-in PWM LED driver, latch applied at period boundary; optional blink via LED_DRV_BLINK_EN
module led_driver_pwm #(
    parameter int CHANNELS     = 8,
    parameter int PWM_BITS     = 4,
    parameter int PRESCALE     = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                si,
    input  logic                shift_en,
    input  logic                ltch,
    input  logic                oe,
    output logic                so,
    output logic [CHANNELS-1:0] out,
    output logic                frame_sync
);
    localparam int L    = CHANNELS * PWM_BITS;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);

    if (CHANNELS < 1 || PWM_BITS < 1 || PWM_BITS > 8 || PRESCALE < 1 || BLINK_FRAMES < 1) begin : g_param_check
        $error("led_driver_pwm: illegal parameter value");
    end

    logic [L-1:0]          sr_q, sr_d, pend_q, pend_d, act_q, act_d;
    logic                  so_q, so_d, ltch_q, pv_q, pv_d, fs_q;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [PS_W-1:0]       ps_q, ps_d;
    logic [CHANNELS-1:0]   out_q, out_d;
    logic                  tick, boundary, lpulse, shift, blank;

    assign lpulse   = ltch & ~ltch_q;
    assign shift    = shift_en & ~ltch;
    assign tick     = (ps_q == PS_MAX);
    assign boundary = tick && (pwm_q == CNT_MAX);

`ifdef LED_DRV_BLINK_EN
    localparam int BL_W = (2 * BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
    logic [BL_W-1:0] bl_q;

    // Count period boundaries; the upper half of the count is the dark half of the blink
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bl_q <= '0;
        end else if (boundary) begin
            bl_q <= (bl_q == BL_W'(2 * BLINK_FRAMES - 1)) ? '0 : bl_q + 1'b1;
        end
    end

    assign blank = (bl_q >= BL_W'(BLINK_FRAMES));
`else
    assign blank = 1'b0;
`endif

    // Next-state for shifter, latch staging, boundary transfer, PWM timing and duty compare
    always_comb begin
        sr_d   = sr_q;
        so_d   = so_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        act_d  = act_q;
        pwm_d  = pwm_q;
        ps_d   = tick ? '0 : ps_q + 1'b1;
        out_d  = '0;

        if (shift) begin
            sr_d = L'({si, sr_q} >> 1);
            so_d = sr_q[0];
        end

        if (lpulse) begin
            pend_d = sr_q;
            pv_d   = 1'b1;
        end

        // A latch in the boundary cycle itself goes straight to active
        if (boundary) begin
            pv_d = 1'b0;
            if (lpulse) begin
                act_d = sr_q;
            end else if (pv_q) begin
                act_d = pend_q;
            end
        end

        if (tick) begin
            pwm_d = boundary ? '0 : pwm_q + 1'b1;
        end

        for (int k = 0; k < CHANNELS; k++) begin
            out_d[k] = !blank && (act_q[k*PWM_BITS +: PWM_BITS] > pwm_q);
        end
    end

    // State registers, all cleared immediately by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q   <= '0;
            so_q   <= 1'b0;
            ltch_q <= 1'b0;
            pend_q <= '0;
            pv_q   <= 1'b0;
            act_q  <= '0;
            pwm_q  <= '0;
            ps_q   <= '0;
            fs_q   <= 1'b0;
            out_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            so_q   <= so_d;
            ltch_q <= ltch;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
            ps_q   <= ps_d;
            fs_q   <= boundary;
            out_q  <= out_d;
        end
    end

    assign so         = so_q;
    assign frame_sync = fs_q;
    assign out        = oe ? out_q : '0;
endmodule
